// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and line/frame total helpers
package vga_timing_pkg;
  localparam int D_CLK_DIV = 2;
  localparam int D_H_DISPLAY = 640;
  localparam int D_H_FRONT = 16;
  localparam int D_H_SYNC = 96;
  localparam int D_H_BACK = 48;
  localparam int D_V_DISPLAY = 480;
  localparam int D_V_FRONT = 10;
  localparam int D_V_SYNC = 2;
  localparam int D_V_BACK = 33;
  localparam int D_BLINK_FRAMES = 30;
  localparam int D_CW = 10;
  function automatic int h_total(input int d, input int f, input int s, input int b);
    return d + f + s + b;
  endfunction
  function automatic int v_total(input int d, input int f, input int s, input int b);
    return d + f + s + b;
  endfunction
endpackage

// File: rtl/vga_timing_gen_pixel_tick_div.sv
// pixel_tick_div: one-clk pixel strobe every CLK_DIV clks while enabled
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic p_tick
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (!enable || cnt == LAST) ? '0 : cnt + DW'(1);
  assign p_tick = enable & ~reset & (cnt == LAST);
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/position generator with run/hold, frame strobe and blink
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = D_CLK_DIV,
  parameter int H_DISPLAY = D_H_DISPLAY,
  parameter int H_FRONT = D_H_FRONT,
  parameter int H_SYNC = D_H_SYNC,
  parameter int H_BACK = D_H_BACK,
  parameter int V_DISPLAY = D_V_DISPLAY,
  parameter int V_FRONT = D_V_FRONT,
  parameter int V_SYNC = D_V_SYNC,
  parameter int V_BACK = D_V_BACK,
  parameter bit SYNC_POL = 1'b0,
  parameter int BLINK_FRAMES = D_BLINK_FRAMES,
  parameter int CW = D_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          frame_start,
  output logic          blink
);
  localparam int HT = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int VT = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] H_VIS = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_LO = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_HI = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_LO = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_HI = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [BW-1:0] F_LAST = BW'(BLINK_FRAMES - 1);
  logic [CW-1:0] h_cnt, v_cnt, h_next, v_next;
  logic [BW-1:0] f_cnt;
  logic h_last, v_last, wrap, hs_on, vs_on;
  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .p_tick(p_tick)
  );
  always_comb begin
    h_last = h_cnt == H_LAST;
    v_last = v_cnt == V_LAST;
    wrap = p_tick & h_last & v_last;
    h_next = h_last ? '0 : h_cnt + CW'(1);
    v_next = h_last ? (v_last ? '0 : v_cnt + CW'(1)) : v_cnt;
    hs_on = h_next >= HS_LO && h_next <= HS_HI;
    vs_on = v_next >= VS_LO && v_next <= VS_HI;
    video_on = enable & (h_cnt < H_VIS) & (v_cnt < V_VIS);
  end
  // syncs are loaded from the next position so they line up with pixel_x/pixel_y
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      frame_start <= 1'b0;
      f_cnt <= '0;
      blink <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (p_tick) begin
        h_cnt <= h_next;
        v_cnt <= v_next;
        hsync <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync <= vs_on ? SYNC_POL : ~SYNC_POL;
      end
      if (wrap) begin
        f_cnt <= f_cnt == F_LAST ? '0 : f_cnt + BW'(1);
        blink <= blink ^ (f_cnt == F_LAST);
      end
    end
  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;
endmodule
